bus_rr_arbiter: RTL and testbench
=================================

# bus_rr_arbiter

Parametrised shared-bus arbiter and packet router, the next generation of our bus generator/arbiter. It sits between DRVRS device-side source FIFOs and DRVRS destination FIFOs and serves requesters in round-robin order. It pops one packet per transaction, decodes the destination ID field, and pushes the packet to one destination or, for the broadcast ID, to every device except the source. It adds destination back-pressure and invalid-ID drop counting.

## Interface
- DRVRS, 4, number of devices on the bus (2..16)
- PCKG_SZ, 16, packet width in bits (must exceed ID_W)
- ID_W, 8, width of destination ID field, located at pkt[PCKG_SZ-1 -: ID_W]
- BROD, 8'hFF, broadcast destination ID (must be ≥ DRVRS)
- clk  input  1  bus clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- pndng  input  DRVRS  bit i high: source FIFO i non-empty; show-ahead data valid on D_pop
- D_pop  input  DRVRS*PCKG_SZ  head data of source FIFO i at slice [i*PCKG_SZ +: PCKG_SZ]
- full  input  DRVRS  bit i high: destination FIFO i cannot accept a push
- pop  output  DRVRS  one-hot, one-cycle pop strobe to source FIFO
- push  output  DRVRS  push strobe(s) to destination FIFOs
- D_push  output  PCKG_SZ  packet driven to all destination FIFOs, qualified by push
- busy  output  1  high whenever FSM is not IDLE
- drop_cnt  output  8  saturating count of packets dropped for invalid destination ID

## Operation
- FSM states: IDLE, POP, ROUTE, WAIT, PUSH; all outputs are Moore, decoded from registered state and registers.
- IDLE: if any pndng bit is set, grant g = first set bit scanning circularly from last_grant+1; register g; go to POP. Otherwise stay.
- POP: pop[g]=1 for exactly this cycle; at the closing edge, latch D_pop slice g into pkt; go to ROUTE.
- ROUTE: dest = pkt ID field.
  - dest == BROD: mask = all ones with bit g cleared.
  - dest < DRVRS: mask = one-hot dest; dest == g is legal (loopback).
  - Otherwise: drop the packet, increment drop_cnt (hold at 255), set last_grant=g, go to IDLE.
  - For a valid dest: if (mask & full)==0 go to PUSH, else go to WAIT.
- WAIT: stay until (mask & full)==0, then go to PUSH. No timeout; other requesters are not served meanwhile.
- PUSH: push = mask and D_push = pkt for this cycle; set last_grant=g; go to IDLE.
- D_push holds the last pushed packet between transactions.
- pndng is sampled only in IDLE. Source FIFOs guarantee a non-empty head once pndng is observed high, so pop is never withdrawn.
- DRVRS==2 broadcast: mask is the single other device.

## Timing
- Reset (async assert, sync deassert assumed from reset tree) forces:
  - state=IDLE, pop=0, push=0, D_push=0, busy=0, drop_cnt=0
  - last_grant=DRVRS-1, so the first grant goes to device 0.
- Reset mid-transaction: the in-flight packet is lost (already popped, if past POP); outputs clear immediately, without waiting for clk.
- Latency with no back-pressure: pndng high in IDLE at edge 0 → pop at cycle 1 → ROUTE at cycle 2 → push at cycle 3 → IDLE at cycle 4.
- Throughput: one packet every 4 cycles under continuous requests. An invalid-ID drop takes 3 cycles.
- Each cycle in WAIT adds exactly one cycle of latency. push rises in the cycle after the edge where full clears for all targeted devices.
- pop and push are never high in the same cycle. At most one pop bit is high at a time.
- Simultaneous requests: strict round-robin order. A device requesting continuously waits at most DRVRS-1 transactions.

## Test plan
- Single unicast: DRVRS=4, pndng=4'b0001, D_pop[0]=16'h02A5, full=0 → pop=0001 at cycle 1, push=0100 with D_push=16'h02A5 at cycle 3, busy high for cycles 1-3.
- Round-robin: pndng=4'b1111 held; all packets target device 0 → pops on devices 0,1,2,3,0 at cycles 1,5,9,13,17.
- Broadcast: device 2 sends 16'hFF3C → push=4'b1011, D_push=16'hFF3C, a single push cycle.
- Back-pressure: unicast to device 1 with full[1]=1 for 5 cycles after ROUTE → FSM holds WAIT, push=0 throughout; push=0010 in the cycle after full[1] falls.
- Invalid ID and saturation: 260 packets with ID 8'h07 → no push ever, drop_cnt reaches 255 and holds; the next valid packet is routed normally.
- Reset mid-op: assert reset during WAIT → pop/push/busy/drop_cnt go to 0 asynchronously. After release with pndng=4'b0100, device 2 is granted (scan starts from 0, and 2 is the first set bit).

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin shared-bus arbiter and packet router.
// Pops one packet per transaction from the granted source FIFO, decodes the
// destination ID, and pushes to one device or (broadcast) all but the source.
// Invalid destination IDs are dropped and counted in a saturating counter.
module bus_rr_arbiter #(
   parameter int              DRVRS   = 4,
   parameter int              PCKG_SZ = 16,
   parameter int              ID_W    = 8,
   parameter logic [ID_W-1:0] BROD    = 8'hFF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DRVRS-1:0]         pndng,
   input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
   input  logic [DRVRS-1:0]         full,
   output logic [DRVRS-1:0]         pop,
   output logic [DRVRS-1:0]         push,
   output logic [PCKG_SZ-1:0]       D_push,
   output logic                     busy,
   output logic [7:0]               drop_cnt
);

   localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

   typedef enum logic [2:0] {IDLE, POP, ROUTE, WAIT, PUSH} state_t;

   state_t             state_q, state_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [GW-1:0]      last_q, last_d;
   logic [PCKG_SZ-1:0] pkt_q, pkt_d;
   logic [PCKG_SZ-1:0] dpush_q, dpush_d;
   logic [DRVRS-1:0]   mask_q, mask_d;
   logic [7:0]         drop_q, drop_d;

   logic [ID_W-1:0]    dest;
   logic [DRVRS-1:0]   route_mask;
   logic               route_ok;
   logic [GW-1:0]      rr_pick;
   logic               rr_found;
   int                 idx;

   // Round-robin pick: first pending requester scanning up from last_grant+1
   always_comb begin
      rr_pick  = last_q;
      rr_found = 1'b0;
      idx      = 0;
      for (int k = 1; k <= DRVRS; k++) begin
         idx = (int'(last_q) + k) % DRVRS;
         if (!rr_found && pndng[idx]) begin
            rr_found = 1'b1;
            rr_pick  = GW'(idx);
         end
      end
   end

   // Destination decode of the latched packet; broadcast excludes the source
   always_comb begin
      dest       = pkt_q[PCKG_SZ-1 -: ID_W];
      route_mask = '0;
      route_ok   = 1'b1;
      if (dest == BROD) begin
         route_mask          = '1;
         route_mask[grant_q] = 1'b0;
      end else if (int'(dest) < DRVRS) begin
         route_mask[dest[GW-1:0]] = 1'b1;
      end else begin
         route_ok = 1'b0;
      end
   end

   // Next-state logic; D_push is only reloaded on entry to PUSH so it holds between packets
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      pkt_d   = pkt_q;
      mask_d  = mask_q;
      dpush_d = dpush_q;
      drop_d  = drop_q;
      unique case (state_q)
         IDLE: begin
            if (rr_found) begin
               grant_d = rr_pick;
               state_d = POP;
            end
         end
         POP: begin
            pkt_d   = D_pop[grant_q*PCKG_SZ +: PCKG_SZ];
            state_d = ROUTE;
         end
         ROUTE: begin
            if (!route_ok) begin
               if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
               last_d  = grant_q;
               state_d = IDLE;
            end else begin
               mask_d = route_mask;
               if ((route_mask & full) == '0) begin
                  dpush_d = pkt_q;
                  state_d = PUSH;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if ((mask_q & full) == '0) begin
               dpush_d = pkt_q;
               state_d = PUSH;
            end
         end
         PUSH: begin
            last_d  = grant_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; last_grant resets so device 0 wins first
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= GW'(DRVRS-1);
         pkt_q   <= '0;
         mask_q  <= '0;
         dpush_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         pkt_q   <= pkt_d;
         mask_q  <= mask_d;
         dpush_q <= dpush_d;
         drop_q  <= drop_d;
      end
   end

   // Moore outputs decoded from registered state
   always_comb begin
      pop      = (state_q == POP)  ? (DRVRS'(1) << grant_q) : '0;
      push     = (state_q == PUSH) ? mask_q : '0;
      D_push   = dpush_q;
      busy     = (state_q != IDLE);
      drop_cnt = drop_q;
   end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: source FIFO model plus push scoreboard.
module tb_bus_rr_arbiter;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   pndng, full, pop, push;
   logic [N*W-1:0] D_pop;
   logic [W-1:0]   D_push;
   logic           busy;
   logic [7:0]     drop_cnt;

   typedef struct packed {
      logic [N-1:0] mask;
      logic [W-1:0] data;
   } exp_t;

   logic [W-1:0] srcq[N][$];
   exp_t         sb[$];
   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;
   int           npush = 0;

   logic [N-1:0] s_pop, s_push;
   logic         s_busy;
   logic [W-1:0] s_dpush;

   bus_rr_arbiter #(.DRVRS(N), .PCKG_SZ(W), .ID_W(8), .BROD(8'hFF)) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
      .pop(pop), .push(push), .D_push(D_push), .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < N; i++) begin
         pndng[i]      = (srcq[i].size() != 0);
         D_pop[i*W +: W] = (srcq[i].size() != 0) ? srcq[i][0] : '0;
      end
   endtask

   function automatic bit qs_empty();
      for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic enq(input int src, input logic [W-1:0] pkt);
      srcq[src].push_back(pkt);
      refresh();
   endtask

   task automatic expect_push(input logic [N-1:0] m, input logic [W-1:0] d);
      exp_t e;
      e.mask = m;
      e.data = d;
      sb.push_back(e);
   endtask

   // One bus cycle: sample at negedge, score pushes, then retire popped heads
   task automatic tick();
      exp_t e;
      @(negedge clk);
      s_pop   = pop;
      s_push  = push;
      s_busy  = busy;
      s_dpush = D_push;
      chk("pop_push_excl", 32'(s_pop & s_push), 32'd0);
      chk("pop_onehot0", 32'($onehot0(s_pop)), 32'd1);
      if (s_push != '0) begin
         npush++;
         if (sb.size() == 0) chk("unexpected_push", 32'(s_push), 32'd0);
         else begin
            e = sb.pop_front();
            chk("push_mask", 32'(s_push), 32'(e.mask));
            chk("push_data", 32'(s_dpush), 32'(e.data));
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (s_pop[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
      refresh();
      cyc++;
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(qs_empty() && !s_busy) && n < bound);
      chk(tag, 32'(qs_empty() && !s_busy), 32'd1);
   endtask

   task automatic do_reset();
      chk("sb_empty_before_reset", 32'(sb.size()), 32'd0);
      reset = 1'b0;
      full  = '0;
      for (int i = 0; i < N; i++) srcq[i].delete();
      refresh();
      tick();
      tick();
      reset = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      int rr_dev[5];
      int rr_cyc[5];
      int k;
      rr_dev = '{0, 1, 2, 3, 0};
      rr_cyc = '{1, 5, 9, 13, 17};

      // Reset state
      reset = 1'b0;
      full  = '0;
      refresh();
      #1;
      chk("rst_pop", 32'(pop), 32'd0);
      chk("rst_push", 32'(push), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dpush", 32'(D_push), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      do_reset();

      // Single unicast: device 0 -> device 2
      enq(0, 16'h02A5);
      expect_push(4'b0100, 16'h02A5);
      tick(); chk("uc_c0_busy", 32'(s_busy), 32'd0);
      tick(); chk("uc_c1_pop", 32'(s_pop), 32'h1); chk("uc_c1_busy", 32'(s_busy), 32'd1);
      tick(); chk("uc_c2_push", 32'(s_push), 32'd0); chk("uc_c2_busy", 32'(s_busy), 32'd1);
      tick(); chk("uc_c3_push", 32'(s_push), 32'h4); chk("uc_c3_dpush", 32'(s_dpush), 32'h02A5);
      tick(); chk("uc_c4_busy", 32'(s_busy), 32'd0); chk("uc_c4_hold", 32'(s_dpush), 32'h02A5);

      // Round-robin with all four requesting, everything targets device 0
      do_reset();
      enq(0, 16'h0011); enq(0, 16'h0012);
      enq(1, 16'h0021); enq(2, 16'h0031); enq(3, 16'h0041);
      expect_push(4'b0001, 16'h0011);
      expect_push(4'b0001, 16'h0021);
      expect_push(4'b0001, 16'h0031);
      expect_push(4'b0001, 16'h0041);
      expect_push(4'b0001, 16'h0012);
      k = 0;
      for (int c = 0; c < 21; c++) begin
         tick();
         if (s_pop != '0) begin
            if (k < 5) begin
               chk("rr_pop_dev", 32'(s_pop), 32'(1) << rr_dev[k]);
               chk("rr_pop_cyc", 32'(cyc - 1), 32'(rr_cyc[k]));
            end
            k++;
         end
      end
      chk("rr_pop_count", 32'(k), 32'd5);
      wait_idle("rr_idle", 20);

      // Broadcast from device 2
      do_reset();
      npush = 0;
      enq(2, 16'hFF3C);
      expect_push(4'b1011, 16'hFF3C);
      wait_idle("bc_idle", 20);
      chk("bc_push_cycles", 32'(npush), 32'd1);

      // Back-pressure: device 0 -> device 1 while full[1] held through cycle 7
      do_reset();
      full = 4'b0010;
      enq(0, 16'h01B7);
      expect_push(4'b0010, 16'h01B7);
      for (int c = 0; c < 10; c++) begin
         tick();
         if (c >= 3 && c <= 8) begin
            chk("bp_wait_push", 32'(s_push), 32'd0);
            chk("bp_wait_busy", 32'(s_busy), 32'd1);
         end
         if (c == 9) chk("bp_push", 32'(s_push), 32'h2);
         if (c == 7) full = '0;
      end
      wait_idle("bp_idle", 10);

      // Invalid ID drops and counter saturation
      do_reset();
      for (int i = 0; i < 100; i++) enq(0, 16'h0700 | 16'(i));
      wait_idle("inv_a_idle", 100 * 3 + 20);
      chk("inv_drop_100", 32'(drop_cnt), 32'd100);
      for (int i = 0; i < 160; i++) enq(0, 16'h0700 | 16'(i));
      wait_idle("inv_b_idle", 160 * 3 + 20);
      chk("inv_drop_sat", 32'(drop_cnt), 32'd255);
      enq(0, 16'h03C4);
      expect_push(4'b1000, 16'h03C4);
      wait_idle("inv_valid_idle", 20);
      chk("inv_valid_sb", 32'(sb.size()), 32'd0);
      chk("inv_drop_hold", 32'(drop_cnt), 32'd255);

      // Reset during WAIT clears outputs without a clock edge
      full = 4'b0010;
      cyc  = 0;
      enq(1, 16'h0155);
      for (int c = 0; c < 5; c++) tick();
      chk("mid_busy_pre", 32'(s_busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_pop", 32'(pop), 32'd0);
      chk("mid_push", 32'(push), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_drop", 32'(drop_cnt), 32'd0);
      do_reset();
      enq(2, 16'h03D2);
      expect_push(4'b1000, 16'h03D2);
      tick();
      tick(); chk("mid_regrant", 32'(s_pop), 32'h4);
      wait_idle("mid_idle", 20);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
